// File: rtl/h80_uart_io_if.sv
// h80 shared-bus control signals seen by an I/O responder.
// Ports (signals): iorq_n, mreq_n, bus_addr, bus_cmd driven by the initiator;
//                  bus_wait_n driven by the responder. bus_data travels as a
//                  separate inout wire on the responder.
interface h80_uart_io_if #(
    parameter int unsigned BUS_ADDR_WIDTH = 16,
    parameter int unsigned BUS_CMD_WIDTH  = 3
);
    logic                      iorq_n;
    logic                      mreq_n;
    logic [BUS_ADDR_WIDTH-1:0] bus_addr;
    logic [BUS_CMD_WIDTH-1:0]  bus_cmd;
    logic                      bus_wait_n;

    modport master (
        output iorq_n, mreq_n, bus_addr, bus_cmd,
        input  bus_wait_n
    );

    modport slave (
        input  iorq_n, mreq_n, bus_addr, bus_cmd,
        output bus_wait_n
    );
endinterface

// File: rtl/h80_uart_io.sv
// Serial-port I/O responder on the h80 bus: RX FIFO fed by a UART receiver,
// TX FIFO drained by a UART transmitter (8N1, CLK_DIV clocks per bit).
// Registers at BASE_ADDR+0 DATA, +1 RXCNT, +2 STAT, +3 CTRL (loopback build).
// Ports: clk, reset (sync, active high), bus (h80_uart_io_if.slave),
//        bus_data (inout, driven only during our reads), uart_rx, uart_tx.
// Build option: define H80_UART_LOOPBACK_EN to add CTRL with the loopback bit.
module h80_uart_io #(
    parameter int unsigned BUS_ADDR_WIDTH = 16,
    parameter int unsigned BUS_CMD_WIDTH  = 3,
    parameter int unsigned BUS_DATA_WIDTH = 16,
    parameter int unsigned BASE_ADDR      = 'h0000,
    parameter int unsigned CLK_DIV        = 234,
    parameter int unsigned RX_DEPTH       = 16,
    parameter int unsigned TX_DEPTH       = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    h80_uart_io_if.slave              bus,
    inout  wire [BUS_DATA_WIDTH-1:0]  bus_data,
    input  logic                      uart_rx,
    output logic                      uart_tx
);
    localparam int unsigned RX_PW = $clog2(RX_DEPTH);
    localparam int unsigned RX_CW = RX_PW + 1;
    localparam int unsigned TX_PW = $clog2(TX_DEPTH);
    localparam int unsigned TX_CW = TX_PW + 1;
    localparam int unsigned CNT_W = $clog2(CLK_DIV);
`ifdef H80_UART_LOOPBACK_EN
    localparam int unsigned NUM_REGS = 4;
`else
    localparam int unsigned NUM_REGS = 3;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // Bus decode; an access completes on any edge where hit and not stalled
    logic [BUS_ADDR_WIDTH-1:0] offset;
    logic hit, is_rd, done, sel_data, sel_stat, sel_ctrl;
    logic tx_full, tx_empty, rx_full, rx_empty;
    assign offset   = bus.bus_addr - BUS_ADDR_WIDTH'(BASE_ADDR);
    assign hit      = !bus.iorq_n && (bus.bus_cmd != '0) && (offset < BUS_ADDR_WIDTH'(NUM_REGS));
    assign is_rd    = bus.bus_cmd[0];
    assign sel_data = hit && (offset[1:0] == 2'd0);
    assign sel_stat = hit && (offset[1:0] == 2'd2);
    assign sel_ctrl = hit && (offset[1:0] == 2'd3);
    assign bus.bus_wait_n = !(sel_data && !is_rd && tx_full);
    assign done     = hit && bus.bus_wait_n;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.mreq_n, bus_data[BUS_DATA_WIDTH-1:8], sel_ctrl};

    // Loopback control
    logic loop_en, tx_line, rx_in;
`ifdef H80_UART_LOOPBACK_EN
    always_ff @(posedge clk) begin
        if (reset)                     loop_en <= 1'b0;
        else if (done && !is_rd && sel_ctrl) loop_en <= bus_data[0];
    end
`else
    assign loop_en = 1'b0;
`endif
    assign rx_in = loop_en ? tx_line : uart_rx;

    // RX FIFO
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_PW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_CW-1:0] rx_count;
    logic             rx_push_req, rx_accept, rx_pop, ferr_set;
    logic [7:0]       rx_shift;
    assign rx_full   = (rx_count == RX_CW'(RX_DEPTH));
    assign rx_empty  = (rx_count == '0);
    assign rx_pop    = done && is_rd && sel_data && !rx_empty;
    // A full FIFO still accepts when the same edge pops an entry
    assign rx_accept = rx_push_req && (!rx_full || rx_pop);

    always_ff @(posedge clk) begin
        if (rx_accept) rx_mem[rx_wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_accept) rx_wr_ptr <= rx_wr_ptr + RX_PW'(1);
            if (rx_pop)    rx_rd_ptr <= rx_rd_ptr + RX_PW'(1);
            case ({rx_accept, rx_pop})
                2'b10:   rx_count <= rx_count + RX_CW'(1);
                2'b01:   rx_count <= rx_count - RX_CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // TX FIFO
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_PW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_CW-1:0] tx_count;
    logic             tx_push, tx_pop;
    assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_push  = done && !is_rd && sel_data;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= bus_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + TX_CW'(1);
                2'b01:   tx_count <= tx_count - TX_CW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // Receiver: 2-FF synchroniser, mid-bit sampling from the start edge
    uart_state_t      rx_state, rx_state_d;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
    logic [2:0]       rx_bit, rx_bit_d;
    logic [7:0]       rx_shift_d;
    logic             rx_s1, rx_s2, rx_s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= rx_in;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state;
        rx_cnt_d    = rx_cnt;
        rx_bit_d    = rx_bit;
        rx_shift_d  = rx_shift;
        rx_push_req = 1'b0;
        ferr_set    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_s3 && !rx_s2) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = CNT_W'(CLK_DIV / 2 - 1);
                end
            end
            S_START: begin
                if (rx_cnt != '0) begin
                    rx_cnt_d = rx_cnt - CNT_W'(1);
                end else if (!rx_s2) begin
                    rx_state_d = S_DATA;
                    rx_cnt_d   = CNT_W'(CLK_DIV - 1);
                    rx_bit_d   = '0;
                end else begin
                    rx_state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_cnt != '0) begin
                    rx_cnt_d = rx_cnt - CNT_W'(1);
                end else begin
                    rx_shift_d = {rx_s2, rx_shift[7:1]};
                    rx_cnt_d   = CNT_W'(CLK_DIV - 1);
                    rx_bit_d   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_cnt != '0) begin
                    rx_cnt_d = rx_cnt - CNT_W'(1);
                end else begin
                    rx_push_req = rx_s2;
                    ferr_set    = !rx_s2;
                    rx_state_d  = S_IDLE;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // Transmitter: each state lasts CLK_DIV clocks; STOP chains into START
    uart_state_t      tx_state, tx_state_d;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_d;
    logic [2:0]       tx_bit, tx_bit_d;
    logic [7:0]       tx_shift, tx_shift_d;
    logic             tx_line_d, tx_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            tx_line  <= tx_line_d;
            uart_tx  <= tx_line_d | loop_en;
        end
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_line_d  = tx_line;
        tx_load    = 1'b0;
        case (tx_state)
            S_IDLE: tx_load = !tx_empty;
            S_START: begin
                if (tx_cnt != '0) begin
                    tx_cnt_d = tx_cnt - CNT_W'(1);
                end else begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = CNT_W'(CLK_DIV - 1);
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift[0];
                end
            end
            S_DATA: begin
                if (tx_cnt != '0) begin
                    tx_cnt_d = tx_cnt - CNT_W'(1);
                end else begin
                    tx_cnt_d = CNT_W'(CLK_DIV - 1);
                    if (tx_bit == 3'd7) begin
                        tx_state_d = S_STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit + 3'd1;
                        tx_shift_d = {1'b0, tx_shift[7:1]};
                        tx_line_d  = tx_shift[1];
                    end
                end
            end
            S_STOP: begin
                if (tx_cnt != '0)   tx_cnt_d   = tx_cnt - CNT_W'(1);
                else if (!tx_empty) tx_load    = 1'b1;
                else                tx_state_d = S_IDLE;
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_load) begin
            tx_shift_d = tx_mem[tx_rd_ptr];
            tx_state_d = S_START;
            tx_cnt_d   = CNT_W'(CLK_DIV - 1);
            tx_line_d  = 1'b0;
        end
    end
    assign tx_pop = tx_load;

    // Sticky error flags; a new error on the clearing edge keeps the flag set
    logic ovr, ferr, stat_clr;
    assign stat_clr = done && is_rd && sel_stat;
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= (rx_push_req && !rx_accept) || (ovr && !stat_clr);
            ferr <= ferr_set || (ferr && !stat_clr);
        end
    end

    // Read data, combinational from registered state
    logic [BUS_DATA_WIDTH-1:0] rdata;
    logic tx_idle;
    assign tx_idle = (tx_state == S_IDLE) && tx_empty;
    always_comb begin
        rdata = '0;
        case (offset[1:0])
            2'd0:    if (!rx_empty) rdata = BUS_DATA_WIDTH'(rx_mem[rx_rd_ptr]);
            2'd1:    rdata = BUS_DATA_WIDTH'(rx_count);
            2'd2:    rdata = BUS_DATA_WIDTH'({ferr, ovr, tx_idle, !tx_full, !rx_empty});
            default: rdata = BUS_DATA_WIDTH'(loop_en);
        endcase
    end
    assign bus_data = (hit && is_rd) ? rdata : {BUS_DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_h80_uart_io.sv
// Bench for h80_uart_io: random RX frames and TX writes against a queue model;
// bus reads and serial TX frames are checked by independent monitors.
module tb_h80_uart_io;
    localparam int unsigned DIV = 8;
`ifdef H80_UART_LOOPBACK_EN
    localparam int unsigned NREG = 4;
`else
    localparam int unsigned NREG = 3;
`endif

    logic clk = 1'b0;
    logic reset;
    logic uart_rx, uart_tx;
    logic [15:0] drv;
    logic drv_en;
    wire  [15:0] bus_data;
    always #5 clk = ~clk;
    assign bus_data = drv_en ? drv : 16'hzzzz;

    h80_uart_io_if #(.BUS_ADDR_WIDTH(16), .BUS_CMD_WIDTH(3)) bus ();

    h80_uart_io #(.CLK_DIV(DIV), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .bus(bus), .bus_data(bus_data),
        .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    int errors = 0;
    int checks = 0;
    int rst_epoch = 0;
    bit loop_mode = 0;

    // Behavioural model and scoreboard queues
    logic [7:0]  rx_model[$];
    bit          m_ovr, m_ferr;
    logic [15:0] exp_rd[$];
    string       rd_name[$];
    logic [7:0]  tx_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.iorq_n   = 1'b1;
        bus.mreq_n   = 1'b1;
        bus.bus_cmd  = 3'b000;
        bus.bus_addr = 16'h0000;
        drv_en       = 1'b0;
    endtask

    task automatic bus_read(input int a, input string nm, input logic [15:0] e);
        exp_rd.push_back(e);
        rd_name.push_back(nm);
        bus.iorq_n   = 1'b0;
        bus.bus_cmd  = 3'b011;
        bus.bus_addr = 16'(a);
        drv_en       = 1'b0;
        hold(1);
        bus_idle();
    endtask

    task automatic bus_write(input int a, input logic [7:0] d, output int stall);
        if (a == 0 && !loop_mode) tx_exp.push_back(d);
        bus.iorq_n   = 1'b0;
        bus.bus_cmd  = 3'b010;
        bus.bus_addr = 16'(a);
        drv          = 16'($urandom);
        drv[7:0]     = d;
        drv_en       = 1'b1;
        stall        = 0;
        @(negedge clk);
        while (bus.bus_wait_n !== 1'b1) begin
            stall++;
            if (stall > 2000) begin
                checks++;
                errors++;
                $display("FAIL write_stall_timeout: wait_n=%b required 1", bus.bus_wait_n);
                break;
            end
            @(negedge clk);
        end
        hold(1);
        bus_idle();
    endtask

    task automatic rd_data();
        logic [15:0] e;
        e = (rx_model.size() != 0) ? 16'(rx_model.pop_front()) : 16'h0000;
        bus_read(0, "rd_data", e);
    endtask

    task automatic rd_cnt();
        bus_read(1, "rd_rxcnt", 16'(rx_model.size()));
    endtask

    // STAT read assumes the transmitter has drained
    task automatic rd_stat();
        bus_read(2, "rd_stat", 16'({m_ferr, m_ovr, 1'b1, 1'b1, rx_model.size() != 0}));
        m_ovr  = 0;
        m_ferr = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good);
        uart_rx = 1'b0;
        hold(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            hold(DIV);
        end
        uart_rx = good;
        hold(DIV);
        if (!good) begin
            uart_rx = 1'b1;
            hold(DIV);
            m_ferr = 1;
        end else if (rx_model.size() < 16) begin
            rx_model.push_back(b);
        end else begin
            m_ovr = 1;
        end
    endtask

    task automatic wait_tx_drain();
        int n = 0;
        while (tx_exp.size() != 0 && n < 5000) begin
            hold(1);
            n++;
        end
        if (tx_exp.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL tx_drain_timeout: %0d bytes pending, required 0", tx_exp.size());
            tx_exp.delete();
        end
        hold(16);
    endtask

    // Bus-read monitor
    logic [15:0] mon_e;
    string       mon_n;
    always @(negedge clk) begin
        if (!reset && !bus.iorq_n && bus.bus_cmd == 3'b011 && bus.bus_addr < 16'(NREG)) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %h, no expected value queued", bus_data);
            end else begin
                mon_e = exp_rd.pop_front();
                mon_n = rd_name.pop_front();
                check(mon_n, 32'(bus_data), 32'(mon_e));
            end
        end
    end

    // Serial TX monitor: mid-bit sampling from the falling start edge
    initial begin : tx_mon
        logic [7:0] b;
        bit ok;
        int ep;
        forever begin
            @(negedge clk);
            if (!reset && uart_tx === 1'b0) begin
                ep = rst_epoch;
                ok = 1;
                repeat (3) @(negedge clk);
                if (uart_tx !== 1'b0) ok = 0;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (DIV) @(negedge clk);
                if (uart_tx !== 1'b1) ok = 0;
                if (ep == rst_epoch) begin
                    if (tx_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx_frame: got %h, none expected", b);
                    end else begin
                        check("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
                        check("tx_framing", 32'(ok), 32'd1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int st, n, k, m;
        int stl[6];
        logic [7:0] b;
        bus_idle();
        uart_rx = 1'b1;
        drv     = 16'h0000;
        m_ovr   = 0;
        m_ferr  = 0;
        reset   = 1'b1;
        hold(3);
        reset = 1'b0;
        hold(1);

        // Reset state and idle bus
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_wait_n", 32'(bus.bus_wait_n), 32'd1);
        rd_cnt();
        rd_stat();
        bus.iorq_n = 1'b0; bus.bus_cmd = 3'b000; bus.bus_addr = 16'd2;
        drv = 16'h0000; drv_en = 1'b1;
        @(negedge clk);
        check("z_cmd_none", 32'(bus_data), 32'h0);
        bus.iorq_n = 1'b1; bus.bus_cmd = 3'b011;
        @(negedge clk);
        check("z_no_iorq", 32'(bus_data), 32'h0);
`ifndef H80_UART_LOOPBACK_EN
        bus.iorq_n = 1'b0; bus.bus_addr = 16'd3;
        @(negedge clk);
        check("z_unmapped", 32'(bus_data), 32'h0);
`endif
        hold(1);
        bus_idle();

        // Single RX frame
        send_frame(8'h41, 1);
        rd_cnt();
        rd_data();
        rd_cnt();
        rd_data();

        // Single TX byte with start latency
        bus_write(0, 8'h61, st);
        check("tx_no_stall", 32'(st), 32'd0);
        check("tx_before_start", 32'(uart_tx), 32'd1);
        hold(1);
        check("tx_start_latency", 32'(uart_tx), 32'd0);
        wait_tx_drain();
        rd_stat();

        // Six back-to-back writes into a 4-deep FIFO
        for (int i = 0; i < 6; i++) bus_write(0, 8'($urandom), stl[i]);
        check("stall_5th", 32'(stl[4]), 32'd0);
        check("stall_6th", 32'(stl[5] != 0), 32'd1);
        wait_tx_drain();

        // Overrun with 17 unread frames
        for (int i = 0; i < 17; i++) send_frame(8'($urandom), 1);
        rd_cnt();
        rd_stat();
        rd_stat();
        for (int i = 0; i < 17; i++) rd_data();

        // Framing error
        send_frame(8'($urandom), 0);
        rd_cnt();
        rd_stat();
        rd_stat();

        // Random rounds: concurrent TX writes and RX frames
        for (int r = 0; r < 4; r++) begin
            k = $urandom_range(0, 3);
            for (int i = 0; i < k; i++) bus_write(0, 8'($urandom), st);
            n = $urandom_range(1, 18);
            for (int i = 0; i < n; i++) send_frame(8'($urandom), $urandom_range(0, 7) != 0);
            wait_tx_drain();
            rd_cnt();
            rd_stat();
            m = $urandom_range(0, rx_model.size() + 1);
            for (int i = 0; i < m; i++) rd_data();
            rd_cnt();
            rd_stat();
        end
        while (rx_model.size() != 0) rd_data();

`ifdef H80_UART_LOOPBACK_EN
        // Internal loopback: byte returns through the receiver, pin stays high
        bus_write(3, 8'h01, st);
        bus_read(3, "rd_ctrl", 16'h0001);
        loop_mode = 1;
        bus_write(0, 8'h5A, st);
        hold(12 * DIV);
        rx_model.push_back(8'h5A);
        rd_cnt();
        rd_data();
        bus_write(3, 8'h00, st);
        loop_mode = 0;
        bus_read(3, "rd_ctrl_off", 16'h0000);
`endif

        // Reset in the middle of a TX frame and a partial RX frame
        b = 8'($urandom);
        bus_write(0, b, st);
        uart_rx = 1'b0;
        hold(20);
        reset = 1'b1;
        rst_epoch++;
        tx_exp.delete();
        rx_model.delete();
        m_ovr = 0;
        m_ferr = 0;
        uart_rx = 1'b1;
        hold(2);
        reset = 1'b0;
        hold(1);
        check("midrst_uart_tx", 32'(uart_tx), 32'd1);
        check("midrst_wait_n", 32'(bus.bus_wait_n), 32'd1);
        rd_cnt();
        rd_stat();
        hold(100);
        send_frame(8'h3C, 1);
        rd_data();
        bus_write(0, 8'hC3, st);
        wait_tx_drain();
        rd_stat();

        hold(4);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
